// File: rtl/tl_arbiter_d.sv
// rtl/tl_arbiter_d.sv - round-robin TileLink D-channel arbiter with multi-beat burst locking
// Optional TL_ARB_D_PERF_EN adds a saturating output-stall counter (perf_stall_cnt_o).
module tl_arbiter_d #(
  parameter int SLAVE_NUM  = 2,
  parameter int DATA_BYTES = 8,
  parameter int SIZE_W     = 4,
  localparam int SEL_W     = (SLAVE_NUM > 2) ? $clog2(SLAVE_NUM) : 1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [SLAVE_NUM-1:0]        inp_valid_i,
  output logic [SLAVE_NUM-1:0]        inp_ready_o,
  input  logic [SLAVE_NUM-1:0]        inp_has_data_i,
  input  logic [SLAVE_NUM*SIZE_W-1:0] inp_size_i,
  output logic                        oup_valid_o,
  input  logic                        oup_ready_i,
  output logic [SEL_W-1:0]            oup_sel_o,
  output logic                        oup_last_o
`ifdef TL_ARB_D_PERF_EN
  ,
  output logic [31:0]                 perf_stall_cnt_o
`endif
);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] lock_q, lock_d;
  logic [8:0]       beat_cnt_q, beat_cnt_d;
  logic [SEL_W-1:0] grant;
  logic             found;
  logic             hs;
  logic [8:0]       cur_beats;

  // 9-bit arithmetic: sizes of 9 and above wrap to zero bytes and count as one beat
  function automatic logic [8:0] calc_beats(input logic has_data, input logic [SIZE_W-1:0] size);
    logic [8:0] bytes;
    bytes = 9'd1 << size;
    if (has_data && (bytes > 9'(DATA_BYTES)))
      return bytes >> $clog2(DATA_BYTES);
    else
      return 9'd1;
  endfunction

  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] cur);
    int n;
    n = int'(cur) + 1;
    if (n >= SLAVE_NUM) n = 0;
    return SEL_W'(n);
  endfunction

  always_comb begin
    int idx;
    idx         = 0;
    grant       = rr_ptr_q;
    found       = 1'b0;
    if (state_q == ST_BURST) begin
      grant = lock_q;
      found = 1'b1;
    end else begin
      for (int i = 0; i < SLAVE_NUM; i++) begin
        idx = (int'(rr_ptr_q) + i) % SLAVE_NUM;
        if (!found && inp_valid_i[idx]) begin
          found = 1'b1;
          grant = SEL_W'(idx);
        end
      end
    end
    cur_beats   = calc_beats(inp_has_data_i[grant], inp_size_i[int'(grant)*SIZE_W +: SIZE_W]);

    oup_valid_o = found & inp_valid_i[grant];
    inp_ready_o = '0;
    if (found) inp_ready_o[grant] = oup_ready_i;
    oup_sel_o   = grant;
    if (state_q == ST_BURST) oup_last_o = (beat_cnt_q == 9'd1);
    else                     oup_last_o = found ? (cur_beats == 9'd1) : 1'b1;

    // While reset is held the outputs look like an empty IDLE regardless of inputs
    if (!rst_ni) begin
      oup_valid_o = 1'b0;
      inp_ready_o = '0;
      oup_sel_o   = '0;
      oup_last_o  = 1'b1;
    end

    hs         = oup_valid_o & oup_ready_i;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (cur_beats == 9'd1) begin
            rr_ptr_d = next_ptr(grant);
          end else begin
            state_d    = ST_BURST;
            lock_d     = grant;
            beat_cnt_d = cur_beats - 9'd1;
          end
        end
      end
      ST_BURST: begin
        if (hs) begin
          beat_cnt_d = beat_cnt_q - 9'd1;
          if (beat_cnt_q == 9'd1) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr(lock_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      lock_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef TL_ARB_D_PERF_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      perf_stall_cnt_o <= '0;
    else if (oup_valid_o && !oup_ready_i && (perf_stall_cnt_o != 32'hFFFF_FFFF))
      perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_tl_arbiter_d.sv
// tb/tb_tl_arbiter_d.sv - directed self-checking bench for tl_arbiter_d (2- and 3-responder instances)
module tb_tl_arbiter_d;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic [1:0] valid, ready_o, has_data;
  logic [7:0] size;
  logic       oready, ovalid, sel, last;
  logic [2:0] v3, r3o, hd3;
  logic [11:0] sz3;
  logic       ovalid3, oready3, last3;
  logic [1:0] sel3;
`ifdef TL_ARB_D_PERF_EN
  logic [31:0] perf, perf3;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk_i = ~clk_i;

  tl_arbiter_d #(.SLAVE_NUM(2), .DATA_BYTES(8), .SIZE_W(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .inp_valid_i(valid), .inp_ready_o(ready_o), .inp_has_data_i(has_data), .inp_size_i(size),
    .oup_valid_o(ovalid), .oup_ready_i(oready), .oup_sel_o(sel), .oup_last_o(last)
`ifdef TL_ARB_D_PERF_EN
    , .perf_stall_cnt_o(perf)
`endif
  );

  tl_arbiter_d #(.SLAVE_NUM(3), .DATA_BYTES(8), .SIZE_W(4)) dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .inp_valid_i(v3), .inp_ready_o(r3o), .inp_has_data_i(hd3), .inp_size_i(sz3),
    .oup_valid_o(ovalid3), .oup_ready_i(oready3), .oup_sel_o(sel3), .oup_last_o(last3)
`ifdef TL_ARB_D_PERF_EN
    , .perf_stall_cnt_o(perf3)
`endif
  );

  // {valid, ready[1:0], sel, last}
  function automatic logic [4:0] obs();
    return {ovalid, ready_o, sel, last};
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; valid = 2'b00; has_data = 2'b00; size = 8'h00; oready = 1'b0;
    v3 = 3'b000; hd3 = 3'b000; sz3 = 12'h000; oready3 = 1'b1;
    #3;
    total++;
    if (obs() !== 5'b0_00_0_1) begin bad++; $display("FAIL reset_idle actual=%b required=%b", obs(), 5'b0_00_0_1); end
    total++;
    if ({ovalid3, r3o, sel3, last3} !== 7'b0_000_00_1) begin bad++; $display("FAIL reset_dut3 actual=%b required=%b", {ovalid3, r3o, sel3, last3}, 7'b0_000_00_1); end
    valid = 2'b11; oready = 1'b1;
    #1;
    total++;
    if (obs() !== 5'b0_00_0_1) begin bad++; $display("FAIL reset_gated actual=%b required=%b", obs(), 5'b0_00_0_1); end
    next_cycle();
  endtask

  task automatic test_round_robin();
    logic [4:0] exp;
    rst_ni = 1'b1; valid = 2'b11; has_data = 2'b00; oready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      #2;
      exp = (b % 2 == 0) ? 5'b1_01_0_1 : 5'b1_10_1_1;
      total++;
      if (obs() !== exp) begin bad++; $display("FAIL rr_beat%0d actual=%b required=%b", b, obs(), exp); end
      next_cycle();
    end
    valid = 2'b00;
  endtask

  task automatic test_burst();
    logic [4:0] exp;
    valid = 2'b10; has_data = 2'b10; size = {4'd6, 4'd0}; oready = 1'b1;
    for (int b = 1; b <= 8; b++) begin
      #2;
      exp = {1'b1, 2'b10, 1'b1, (b == 8)};
      total++;
      if (obs() !== exp) begin bad++; $display("FAIL burst_beat%0d actual=%b required=%b", b, obs(), exp); end
      next_cycle();
      if (b == 1) valid = 2'b11;
    end
    #2;
    total++;
    if (obs() !== 5'b1_01_0_1) begin bad++; $display("FAIL burst_after actual=%b required=%b", obs(), 5'b1_01_0_1); end
    next_cycle();
    valid = 2'b00;
  endtask

  task automatic test_stall();
    logic [4:0] exp;
    int done;
    done = 0;
    valid = 2'b10; has_data = 2'b10; size = {4'd6, 4'd0};
    for (int c = 0; c < 11; c++) begin
      oready = !(c >= 2 && c < 5);
      #2;
      exp = {1'b1, oready ? 2'b10 : 2'b00, 1'b1, (done == 7)};
      total++;
      if (obs() !== exp) begin bad++; $display("FAIL stall_cyc%0d actual=%b required=%b", c, obs(), exp); end
      if (oready) done++;
      next_cycle();
    end
    valid = 2'b00; oready = 1'b1;
    #2;
    total++;
    if (obs() !== 5'b0_00_0_1) begin bad++; $display("FAIL stall_end actual=%b required=%b", obs(), 5'b0_00_0_1); end
`ifdef TL_ARB_D_PERF_EN
    total++;
    if (perf !== 32'd3) begin bad++; $display("FAIL perf_stall actual=%0d required=3", perf); end
`endif
    next_cycle();
  endtask

  task automatic test_single_beat();
    logic [3:0] vs [5] = '{4'd3, 4'd4, 4'd6, 4'd2, 4'd8};
    logic       vh [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       vl [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    valid = 2'b01; has_data = 2'b01; size = {4'd0, 4'd2}; oready = 1'b1;
    #2;
    total++;
    if (obs() !== 5'b1_01_0_1) begin bad++; $display("FAIL small_beat actual=%b required=%b", obs(), 5'b1_01_0_1); end
    next_cycle();
    valid = 2'b00;
    #2;
    total++;
    if (obs() !== 5'b0_00_1_1) begin bad++; $display("FAIL small_idle actual=%b required=%b", obs(), 5'b0_00_1_1); end
    oready = 1'b0; valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      size = {vs[k], 4'd0}; has_data = {vh[k], 1'b0};
      #1;
      total++;
      if ({sel, last} !== {1'b1, vl[k]}) begin bad++; $display("FAIL size_vec%0d actual=%b required=%b", k, {sel, last}, {1'b1, vl[k]}); end
    end
    valid = 2'b00;
    next_cycle();
  endtask

  task automatic test_reset_mid_burst();
    valid = 2'b10; has_data = 2'b10; size = {4'd6, 4'd0}; oready = 1'b1;
    for (int b = 1; b <= 3; b++) next_cycle();
    #2;
    total++;
    if (obs() !== 5'b1_10_1_0) begin bad++; $display("FAIL mid_beat4 actual=%b required=%b", obs(), 5'b1_10_1_0); end
    rst_ni = 1'b0;
    #1;
    total++;
    if (obs() !== 5'b0_00_0_1) begin bad++; $display("FAIL mid_reset actual=%b required=%b", obs(), 5'b0_00_0_1); end
    next_cycle();
    rst_ni = 1'b1; valid = 2'b11; has_data = 2'b00;
    #2;
    total++;
    if (obs() !== 5'b1_01_0_1) begin bad++; $display("FAIL mid_release actual=%b required=%b", obs(), 5'b1_01_0_1); end
    next_cycle();
    valid = 2'b00;
  endtask

  task automatic test_wrap();
    v3 = 3'b010; oready3 = 1'b1;
    #2;
    total++;
    if ({ovalid3, r3o, sel3} !== 6'b1_010_01) begin bad++; $display("FAIL wrap_prep actual=%b required=%b", {ovalid3, r3o, sel3}, 6'b1_010_01); end
    next_cycle();
    v3 = 3'b001;
    #2;
    total++;
    if ({ovalid3, r3o, sel3, last3} !== 7'b1_001_00_1) begin bad++; $display("FAIL wrap_grant actual=%b required=%b", {ovalid3, r3o, sel3, last3}, 7'b1_001_00_1); end
    next_cycle();
    v3 = 3'b000;
    #2;
    total++;
    if ({ovalid3, r3o, sel3, last3} !== 7'b0_000_01_1) begin bad++; $display("FAIL wrap_ptr actual=%b required=%b", {ovalid3, r3o, sel3, last3}, 7'b0_000_01_1); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst();
    test_stall();
    test_single_beat();
    test_reset_mid_burst();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
